// File: rtl/ifm_row_loader_pkg.sv
// ifm_row_loader_pkg: shared widths, FSM encoding and helpers for the IFM row loader.
package ifm_row_loader_pkg;
    localparam int W_SIZE         = 16;
    localparam int IFM_BUFFER     = 2;
    localparam int IFM_BUFFER_CNT = 1 << IFM_BUFFER;
    localparam int W_DRAM_ADDR    = 32;
    localparam int W_DATA         = 32;
    localparam logic [W_DRAM_ADDR-1:0] BYTES_PER_WORD = W_DRAM_ADDR'(W_DATA / 8);

    typedef enum logic [2:0] {
        IFM_LD_IDLE = 3'd0,
        IFM_LD_ADDR = 3'd1,
        IFM_LD_DATA = 3'd2,
        IFM_LD_ZERO = 3'd3,
        IFM_LD_DONE = 3'd4
    } ifm_ld_state_t;

    function automatic logic is_onehot(input logic [IFM_BUFFER_CNT-1:0] v);
        return (v != '0) && ((v & (v - IFM_BUFFER_CNT'(1))) == '0);
    endfunction
endpackage

// File: rtl/ifm_row_addr_gen.sv
// ifm_row_addr_gen: registered DRAM byte address of an IFM row, loaded when a command is accepted.
module ifm_row_addr_gen
    import ifm_row_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_load,
    input  logic [W_DRAM_ADDR-1:0] i_base_addr,
    input  logic [W_SIZE-1:0]      i_row,
    input  logic [W_SIZE-1:0]      i_row_words,
    output logic [W_DRAM_ADDR-1:0] o_addr
);
    logic [W_DRAM_ADDR-1:0] r_addr;
    logic [W_DRAM_ADDR-1:0] w_addr;

    assign w_addr = i_base_addr + W_DRAM_ADDR'(i_row) * W_DRAM_ADDR'(i_row_words) * BYTES_PER_WORD;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_addr <= '0;
        else if (i_load) r_addr <= w_addr;

    assign o_addr = r_addr;
endmodule

// File: rtl/ifm_row_loader.sv
// ifm_row_loader: fetches one IFM row from DRAM (or zero-fills padding rows) into the selected row buffer.
module ifm_row_loader
    import ifm_row_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [IFM_BUFFER_CNT-1:0] i_buf_sel,
    input  logic [W_SIZE-1:0]         i_buf_row,
    input  logic [W_DRAM_ADDR-1:0]    i_base_addr,
    input  logic [W_SIZE-1:0]         i_row_words,
    input  logic [W_SIZE-1:0]         i_ifm_height,
    output logic                      o_rd_req_valid,
    input  logic                      i_rd_req_ready,
    output logic [W_DRAM_ADDR-1:0]    o_rd_addr,
    output logic [W_SIZE-1:0]         o_rd_len,
    input  logic                      i_rd_data_valid,
    input  logic [W_DATA-1:0]         i_rd_data,
    output logic                      o_rd_data_ready,
    output logic [IFM_BUFFER_CNT-1:0] o_wr_en,
    output logic [W_SIZE-1:0]         o_wr_addr,
    output logic [W_DATA-1:0]         o_wr_data,
    output logic [IFM_BUFFER_CNT-1:0] o_buf_done,
    output logic                      o_busy,
    output logic                      o_err
);
    ifm_ld_state_t             r_state, w_next;
    logic [IFM_BUFFER_CNT-1:0] r_sel, r_wr_en;
    logic [W_SIZE-1:0]         r_len, r_cnt, r_wr_addr;
    logic [W_DATA-1:0]         r_wr_data;
    logic                      r_err;
    logic                      w_accept, w_beat, w_zero;

    assign w_accept        = (r_state == IFM_LD_IDLE) && is_onehot(i_buf_sel);
    assign w_zero          = r_state == IFM_LD_ZERO;
    // Ready drops once all beats are in, so a surplus beat is never taken.
    assign o_rd_data_ready = (r_state == IFM_LD_DATA) && (r_cnt != r_len);
    assign w_beat          = o_rd_data_ready && i_rd_data_valid;

    ifm_row_addr_gen u_addr_gen (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_accept),
        .i_base_addr (i_base_addr),
        .i_row       (i_buf_row),
        .i_row_words (i_row_words),
        .o_addr      (o_rd_addr)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_state <= IFM_LD_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IFM_LD_IDLE:
                if (w_accept) begin
                    if (i_row_words == '0) w_next = IFM_LD_DONE;
                    else if (i_buf_row >= i_ifm_height) w_next = IFM_LD_ZERO;
                    else w_next = IFM_LD_ADDR;
                end
            IFM_LD_ADDR: if (i_rd_req_ready) w_next = IFM_LD_DATA;
            IFM_LD_DATA: if (r_cnt == r_len) w_next = IFM_LD_DONE;
            IFM_LD_ZERO: if (r_cnt == r_len - W_SIZE'(1)) w_next = IFM_LD_DONE;
            default:     w_next = IFM_LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_sel     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel <= i_buf_sel;
                r_len <= i_row_words;
                r_cnt <= '0;
            end else if (w_beat || w_zero) begin
                r_cnt <= r_cnt + W_SIZE'(1);
            end
            r_wr_en <= w_beat ? r_sel : '0;
            if (w_beat) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= i_rd_data;
            end
            r_err <= r_err | ((i_buf_sel != '0) && !w_accept);
        end

    // Zero-fill writes straight from the counter so the first lands in the cycle after acceptance.
    assign o_wr_en        = w_zero ? r_sel : r_wr_en;
    assign o_wr_addr      = w_zero ? r_cnt : r_wr_addr;
    assign o_wr_data      = w_zero ? '0 : r_wr_data;
    assign o_rd_req_valid = r_state == IFM_LD_ADDR;
    assign o_rd_len       = r_len;
    assign o_buf_done     = (r_state == IFM_LD_DONE) ? r_sel : '0;
    assign o_busy         = r_state != IFM_LD_IDLE;
    assign o_err          = r_err;
endmodule
